// File: rtl/axil_arbiter_2to1.sv
// axil_arbiter_2to1: round-robin 2:1 AXI4-Lite arbiter, one whole transaction at a time.
module axil_arbiter_2to1 #(
    parameter int dataWidth = 32,
    parameter int addrWidth = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s0_awvalid,
    output logic                   s0_awready,
    input  logic [addrWidth-1:0]   s0_awaddr,
    input  logic [2:0]             s0_awprot,
    input  logic                   s0_wvalid,
    output logic                   s0_wready,
    input  logic [dataWidth-1:0]   s0_wdata,
    input  logic [dataWidth/8-1:0] s0_wstrb,
    output logic                   s0_bvalid,
    input  logic                   s0_bready,
    output logic [1:0]             s0_bresp,
    input  logic                   s0_arvalid,
    output logic                   s0_arready,
    input  logic [addrWidth-1:0]   s0_araddr,
    input  logic [2:0]             s0_arprot,
    output logic                   s0_rvalid,
    input  logic                   s0_rready,
    output logic [dataWidth-1:0]   s0_rdata,
    output logic [1:0]             s0_rresp,
    input  logic                   s1_awvalid,
    output logic                   s1_awready,
    input  logic [addrWidth-1:0]   s1_awaddr,
    input  logic [2:0]             s1_awprot,
    input  logic                   s1_wvalid,
    output logic                   s1_wready,
    input  logic [dataWidth-1:0]   s1_wdata,
    input  logic [dataWidth/8-1:0] s1_wstrb,
    output logic                   s1_bvalid,
    input  logic                   s1_bready,
    output logic [1:0]             s1_bresp,
    input  logic                   s1_arvalid,
    output logic                   s1_arready,
    input  logic [addrWidth-1:0]   s1_araddr,
    input  logic [2:0]             s1_arprot,
    output logic                   s1_rvalid,
    input  logic                   s1_rready,
    output logic [dataWidth-1:0]   s1_rdata,
    output logic [1:0]             s1_rresp,
    output logic                   m_awvalid,
    input  logic                   m_awready,
    output logic [addrWidth-1:0]   m_awaddr,
    output logic [2:0]             m_awprot,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    output logic [dataWidth-1:0]   m_wdata,
    output logic [dataWidth/8-1:0] m_wstrb,
    input  logic                   m_bvalid,
    output logic                   m_bready,
    input  logic [1:0]             m_bresp,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    output logic [addrWidth-1:0]   m_araddr,
    output logic [2:0]             m_arprot,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    input  logic [dataWidth-1:0]   m_rdata,
    input  logic [1:0]             m_rresp,
    output logic                   grant,
    output logic                   busy
);
    typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA} state_t;
    state_t r_state;
    logic   r_grant, r_last;
    logic   w_req0, w_req1, w_win, w_win_aw;
    logic   w_aw, w_w, w_b, w_ar, w_r, w_g0, w_g1;
    assign w_req0   = s0_awvalid | s0_arvalid;
    assign w_req1   = s1_awvalid | s1_arvalid;
    // On a tie the master that did not go last wins.
    assign w_win    = (w_req0 & w_req1) ? ~r_last : w_req1;
    assign w_win_aw = w_win ? s1_awvalid : s0_awvalid;
    assign w_aw = r_state == W_ADDR;
    assign w_w  = r_state == W_DATA;
    assign w_b  = r_state == W_RESP;
    assign w_ar = r_state == R_ADDR;
    assign w_r  = r_state == R_DATA;
    assign w_g0 = ~r_grant;
    assign w_g1 = r_grant;
    assign grant = r_grant;
    assign busy  = r_state != IDLE;
    always_comb begin
        m_awvalid  = w_aw & (r_grant ? s1_awvalid : s0_awvalid);
        m_awaddr   = w_aw ? (r_grant ? s1_awaddr : s0_awaddr) : '0;
        m_awprot   = w_aw ? (r_grant ? s1_awprot : s0_awprot) : '0;
        m_wvalid   = w_w & (r_grant ? s1_wvalid : s0_wvalid);
        m_wdata    = w_w ? (r_grant ? s1_wdata : s0_wdata) : '0;
        m_wstrb    = w_w ? (r_grant ? s1_wstrb : s0_wstrb) : '0;
        m_bready   = w_b & (r_grant ? s1_bready : s0_bready);
        m_arvalid  = w_ar & (r_grant ? s1_arvalid : s0_arvalid);
        m_araddr   = w_ar ? (r_grant ? s1_araddr : s0_araddr) : '0;
        m_arprot   = w_ar ? (r_grant ? s1_arprot : s0_arprot) : '0;
        m_rready   = w_r & (r_grant ? s1_rready : s0_rready);
        s0_awready = w_aw & w_g0 & m_awready;
        s1_awready = w_aw & w_g1 & m_awready;
        s0_wready  = w_w & w_g0 & m_wready;
        s1_wready  = w_w & w_g1 & m_wready;
        s0_bvalid  = w_b & w_g0 & m_bvalid;
        s1_bvalid  = w_b & w_g1 & m_bvalid;
        s0_bresp   = (w_b & w_g0) ? m_bresp : 2'b0;
        s1_bresp   = (w_b & w_g1) ? m_bresp : 2'b0;
        s0_arready = w_ar & w_g0 & m_arready;
        s1_arready = w_ar & w_g1 & m_arready;
        s0_rvalid  = w_r & w_g0 & m_rvalid;
        s1_rvalid  = w_r & w_g1 & m_rvalid;
        s0_rdata   = (w_r & w_g0) ? m_rdata : '0;
        s1_rdata   = (w_r & w_g1) ? m_rdata : '0;
        s0_rresp   = (w_r & w_g0) ? m_rresp : 2'b0;
        s1_rresp   = (w_r & w_g1) ? m_rresp : 2'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (w_req0 | w_req1) begin
                    r_grant <= w_win;
                    r_state <= w_win_aw ? W_ADDR : R_ADDR;
                end
                W_ADDR: if (m_awvalid & m_awready) r_state <= W_DATA;
                W_DATA: if (m_wvalid & m_wready) r_state <= W_RESP;
                W_RESP: if (m_bvalid & m_bready) begin
                    r_state <= IDLE;
                    r_last  <= r_grant;
                end
                R_ADDR: if (m_arvalid & m_arready) r_state <= R_DATA;
                R_DATA: if (m_rvalid & m_rready) begin
                    r_state <= IDLE;
                    r_last  <= r_grant;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// tb_axil_arbiter_2to1: directed checks of arbitration, forwarding, gating, backpressure and reset.
module tb_axil_arbiter_2to1;
    logic        clk = 1'b0, rst = 1'b1;
    logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic [31:0] s0_awaddr, s0_wdata, s0_araddr, s0_rdata;
    logic [2:0]  s0_awprot, s0_arprot;
    logic [3:0]  s0_wstrb;
    logic [1:0]  s0_bresp, s0_rresp;
    logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic [31:0] s1_awaddr, s1_wdata, s1_araddr, s1_rdata;
    logic [2:0]  s1_awprot, s1_arprot;
    logic [3:0]  s1_wstrb;
    logic [1:0]  s1_bresp, s1_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        grant, busy;
    int          n_vec = 0, n_err = 0;

    axil_arbiter_2to1 dut (
        .clk(clk), .rst(rst),
        .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr), .s0_awprot(s0_awprot),
        .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
        .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bresp(s0_bresp),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr), .s0_arprot(s0_arprot),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(s1_awaddr), .s1_awprot(s1_awprot),
        .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
        .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bresp(s1_bresp),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr), .s1_arprot(s1_arprot),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        {s0_awvalid, s0_wvalid, s0_bready, s0_arvalid, s0_rready} = '0;
        {s1_awvalid, s1_wvalid, s1_bready, s1_arvalid, s1_rready} = '0;
        {s0_awaddr, s0_wdata, s0_araddr, s0_awprot, s0_arprot, s0_wstrb} = '0;
        {s1_awaddr, s1_wdata, s1_araddr, s1_awprot, s1_arprot, s1_wstrb} = '0;
        {m_awready, m_wready, m_arready, m_bvalid, m_rvalid} = '1;
        m_bresp = 2'd0;
        m_rdata = 32'h12345678;
        m_rresp = 2'd2;
        // reset state
        @(negedge clk);
        s0_awvalid = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_awvalid", m_awvalid, 0);
        check("rst_awready", s0_awready, 0);
        check("rst_rdata", s0_rdata, 0);
        @(negedge clk);
        s0_awvalid = 1'b0;
        rst = 1'b0;
        // single write from master 0
        s0_awvalid = 1'b1; s0_awaddr = 32'h10; s0_wvalid = 1'b1;
        s0_wdata = 32'hDEADBEEF; s0_wstrb = 4'hF; s0_bready = 1'b1;
        #1;
        check("w1_idle_awvalid", m_awvalid, 0);
        check("w1_idle_busy", busy, 0);
        @(negedge clk); #1;
        check("w1_aw_busy", busy, 1);
        check("w1_aw_grant", grant, 0);
        check("w1_m_awvalid", m_awvalid, 1);
        check("w1_m_awaddr", m_awaddr, 32'h10);
        check("w1_s0_awready", s0_awready, 1);
        check("w1_early_wready", s0_wready, 0);
        check("w1_early_wvalid", m_wvalid, 0);
        @(negedge clk); s0_awvalid = 1'b0; #1;
        check("w1_m_wvalid", m_wvalid, 1);
        check("w1_m_wdata", m_wdata, 32'hDEADBEEF);
        check("w1_m_wstrb", m_wstrb, 4'hF);
        check("w1_s0_wready", s0_wready, 1);
        check("w1_awaddr_gated", m_awaddr, 0);
        @(negedge clk); s0_wvalid = 1'b0; #1;
        check("w1_s0_bvalid", s0_bvalid, 1);
        check("w1_m_bready", m_bready, 1);
        check("w1_b_grant", grant, 0);
        @(negedge clk); #1;
        check("w1_done_busy", busy, 0);
        check("w1_done_bvalid", s0_bvalid, 0);
        // read from master 1
        s1_arvalid = 1'b1; s1_araddr = 32'h24; s1_rready = 1'b1;
        @(negedge clk); #1;
        check("r1_grant", grant, 1);
        check("r1_m_arvalid", m_arvalid, 1);
        check("r1_m_araddr", m_araddr, 32'h24);
        check("r1_s1_arready", s1_arready, 1);
        check("r1_s0_arready", s0_arready, 0);
        @(negedge clk); s1_arvalid = 1'b0; #1;
        check("r1_s1_rvalid", s1_rvalid, 1);
        check("r1_s1_rdata", s1_rdata, 32'h12345678);
        check("r1_s1_rresp", s1_rresp, 2);
        check("r1_m_rready", m_rready, 1);
        check("r1_s0_rvalid", s0_rvalid, 0);
        check("r1_s0_rdata", s0_rdata, 0);
        check("r1_s0_rresp", s0_rresp, 0);
        @(negedge clk); #1;
        check("r1_done_busy", busy, 0);
        check("r1_done_grant", grant, 1);
        // contention: both masters stream writes, master 1 went last
        s0_awvalid = 1'b1; s0_awaddr = 32'h100; s0_wvalid = 1'b1; s0_wdata = 32'hA0;
        s1_awvalid = 1'b1; s1_awaddr = 32'h200; s1_wvalid = 1'b1; s1_wdata = 32'hB0;
        s1_wstrb = 4'h1; s1_bready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk); #1;
            check($sformatf("ct%0d_grant", t), grant, t % 2);
            check($sformatf("ct%0d_awaddr", t), m_awaddr, (t % 2) ? 32'h200 : 32'h100);
            check($sformatf("ct%0d_aw_excl", t), s0_awready & s1_awready, 0);
            check($sformatf("ct%0d_s0_awready", t), s0_awready, (t % 2) ? 0 : 1);
            @(negedge clk); #1;
            check($sformatf("ct%0d_wdata", t), m_wdata, (t % 2) ? 32'hB0 : 32'hA0);
            @(negedge clk); #1;
            check($sformatf("ct%0d_b", t), {s1_bvalid, s0_bvalid}, (t % 2) ? 2'b10 : 2'b01);
            @(negedge clk);
            if (t == 3) {s0_awvalid, s0_wvalid, s1_awvalid, s1_wvalid} = '0;
            #1;
            check($sformatf("ct%0d_idle", t), busy, 0);
        end
        // same master AW+AR: write first, AR held off until after B
        s0_awvalid = 1'b1; s0_awaddr = 32'h30; s0_wvalid = 1'b1; s0_wdata = 32'hA5A5A5A5;
        s0_arvalid = 1'b1; s0_araddr = 32'h40; s0_rready = 1'b1; m_bresp = 2'd1;
        @(negedge clk); #1;
        check("sp_aw_grant", grant, 0);
        check("sp_m_awvalid", m_awvalid, 1);
        check("sp_aw_arvalid", m_arvalid, 0);
        @(negedge clk); s0_awvalid = 1'b0; #1;
        check("sp_w_arvalid", m_arvalid, 0);
        check("sp_w_wdata", m_wdata, 32'hA5A5A5A5);
        @(negedge clk); s0_wvalid = 1'b0; #1;
        check("sp_b_arvalid", m_arvalid, 0);
        check("sp_b_bvalid", s0_bvalid, 1);
        check("sp_b_bresp", s0_bresp, 1);
        @(negedge clk); #1;
        check("sp_idle_arvalid", m_arvalid, 0);
        check("sp_idle_busy", busy, 0);
        @(negedge clk); #1;
        check("sp_ar_arvalid", m_arvalid, 1);
        check("sp_ar_araddr", m_araddr, 32'h40);
        check("sp_ar_grant", grant, 0);
        @(negedge clk); s0_arvalid = 1'b0; #1;
        check("sp_r_rvalid", s0_rvalid, 1);
        check("sp_r_rdata", s0_rdata, 32'h12345678);
        @(negedge clk); #1;
        check("sp_done_busy", busy, 0);
        // backpressure on AW, W and B for 3 cycles each
        m_bresp = 2'd0;
        s0_awvalid = 1'b1; s0_awaddr = 32'h50; s0_wvalid = 1'b1; s0_wdata = 32'hCAFEF00D;
        s0_wstrb = 4'h3; s0_bready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check($sformatf("bp_aw%0d_valid", k), m_awvalid, 1);
            check($sformatf("bp_aw%0d_addr", k), m_awaddr, 32'h50);
            check($sformatf("bp_aw%0d_ready", k), s0_awready, 0);
        end
        @(negedge clk); m_awready = 1'b1; #1;
        check("bp_aw_hs", s0_awready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); s0_awvalid = 1'b0; #1;
            check($sformatf("bp_w%0d_awvalid", k), m_awvalid, 0);
            check($sformatf("bp_w%0d_data", k), m_wdata, 32'hCAFEF00D);
            check($sformatf("bp_w%0d_strb", k), m_wstrb, 4'h3);
            check($sformatf("bp_w%0d_ready", k), s0_wready, 0);
        end
        @(negedge clk); m_wready = 1'b1; #1;
        check("bp_w_hs", s0_wready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); s0_wvalid = 1'b0; #1;
            check($sformatf("bp_b%0d_wvalid", k), m_wvalid, 0);
            check($sformatf("bp_b%0d_bvalid", k), s0_bvalid, 1);
            check($sformatf("bp_b%0d_bready", k), m_bready, 0);
        end
        @(negedge clk); s0_bready = 1'b1; #1;
        check("bp_b_hs", m_bready, 1);
        @(negedge clk); #1;
        check("bp_done_busy", busy, 0);
        check("bp_done_bvalid", s0_bvalid, 0);
        // reset in the middle of a master-1 write, then a master-1 read
        s1_awvalid = 1'b1; s1_awaddr = 32'h60; s1_wvalid = 1'b1; s1_wdata = 32'h11;
        @(negedge clk); #1;
        check("rw_aw_grant", grant, 1);
        @(negedge clk); s1_awvalid = 1'b0; #1;
        check("rw_w_valid", m_wvalid, 1);
        rst = 1'b1; #1;
        check("rw_rst_busy", busy, 0);
        check("rw_rst_wvalid", m_wvalid, 0);
        check("rw_rst_grant", grant, 0);
        check("rw_rst_wready", s1_wready, 0);
        @(negedge clk);
        rst = 1'b0; s1_wvalid = 1'b0;
        s1_arvalid = 1'b1; s1_araddr = 32'h70; #1;
        check("rw_idle_busy", busy, 0);
        @(negedge clk); #1;
        check("rw_ar_grant", grant, 1);
        check("rw_ar_araddr", m_araddr, 32'h70);
        @(negedge clk); s1_arvalid = 1'b0; #1;
        check("rw_r_rvalid", s1_rvalid, 1);
        check("rw_r_rdata", s1_rdata, 32'h12345678);
        @(negedge clk); #1;
        check("rw_done_busy", busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
